// File: rtl/shifter_pkg.sv
// Shared types and pipeline partition helpers for the ARM-style shifter.
// Unit 0 is decode; units 1..log2(W) are the mux levels.
package shifter_pkg;

    typedef enum logic [1:0] {
        LSL = 2'b00,
        LSR = 2'b01,
        ASR = 2'b10,
        ROR = 2'b11
    } shift_type_t;

    typedef enum logic [2:0] {
        OP_LSL,
        OP_LSR,
        OP_ASR,
        OP_ROR,
        OP_RRX,
        OP_PASS
    } eff_op_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Earlier stages absorb the remainder units.
    function automatic int stage_units(input int units, input int stages, input int s);
        return units / stages + ((s < units % stages) ? 1 : 0);
    endfunction

    function automatic int first_unit(input int units, input int stages, input int s);
        int f;
        f = 0;
        for (int i = 0; i < s; i++) f += stage_units(units, stages, i);
        return f;
    endfunction

    function automatic int last_unit(input int units, input int stages, input int s);
        return first_unit(units, stages, s) + stage_units(units, stages, s) - 1;
    endfunction

    function automatic int stage_of(input int units, input int stages, input int u);
        int st;
        st = 0;
        for (int i = 0; i < stages; i++)
            if (u >= first_unit(units, stages, i)) st = i;
        return st;
    endfunction

endpackage

// File: rtl/pipelined_shifter_level.sv
// One combinational mux level of the barrel shifter (distance 2**BIT).
// Carry tracks the last bit shifted out, so chained levels compose.
module shifter_level
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int AMT_W = 5,
    parameter int BIT   = 0
) (
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_carry,
    input  eff_op_t          i_op,
    input  logic [AMT_W-1:0] i_amt,
    output logic [WIDTH-1:0] o_data,
    output logic             o_carry,
    output eff_op_t          o_op,
    output logic [AMT_W-1:0] o_amt
);

    localparam int DIST = 1 << BIT;

    always_comb begin
        o_data     = i_data;
        o_carry    = i_carry;
        o_op       = i_op;
        o_amt      = i_amt;
        o_amt[BIT] = 1'b0;
        if (i_amt[BIT]) begin
            case (i_op)
                OP_LSL: begin
                    o_data  = i_data << DIST;
                    o_carry = i_data[WIDTH-DIST];
                end
                OP_LSR: begin
                    o_data  = i_data >> DIST;
                    o_carry = i_data[DIST-1];
                end
                OP_ASR: begin
                    o_data  = WIDTH'($signed(i_data) >>> DIST);
                    o_carry = i_data[DIST-1];
                end
                OP_ROR: begin
                    o_data  = (i_data >> DIST) | (i_data << (WIDTH - DIST));
                    o_carry = i_data[DIST-1];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined ARM barrel shifter with carry-out and a global-stall handshake.
// Decode folds all #0 / saturation cases; levels only see in-range amounts.
module pipelined_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int AMT_W  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       shift_type,
    input  logic [AMT_W-1:0] shift_num,
    input  logic             imm,
    input  logic             not_shift,
    input  logic             carry_in,
    input  logic [WIDTH-1:0] x,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             carry_out
);

    localparam int L = clog2(WIDTH);
    localparam int U = L + 1;
    localparam logic [AMT_W-1:0] W_A = AMT_W'(WIDTH);

    logic [WIDTH-1:0] w_d   [U];
    logic             w_c   [U];
    eff_op_t          w_op  [U];
    logic [L-1:0]     w_amt [U];

    logic [WIDTH-1:0] w_cd   [STAGES];
    logic             w_cc   [STAGES];
    eff_op_t          w_cop  [STAGES];
    logic [L-1:0]     w_camt [STAGES];

    logic [WIDTH-1:0] r_data  [STAGES];
    logic             r_carry [STAGES];
    eff_op_t          r_op    [STAGES];
    logic [L-1:0]     r_amt   [STAGES];
    logic [STAGES-1:0] r_valid;

    shift_type_t      w_type;
    logic [AMT_W-1:0] w_n;
    logic             w_sat;
    logic             w_zero;
    logic [WIDTH-1:0] w_dec_d;
    logic             w_dec_c;
    eff_op_t          w_dec_op;
    logic [L-1:0]     w_dec_amt;
    logic             w_advance;
    logic [STAGES:0]  w_vchain;
    logic             w_unused;

    assign w_type = shift_type_t'(shift_type);
    assign w_zero = (shift_num == '0);

    always_comb begin
        w_dec_d   = x;
        w_dec_c   = carry_in;
        w_dec_op  = OP_PASS;
        w_dec_amt = '0;
        w_n       = shift_num;
        if (imm && w_zero && (w_type == LSR || w_type == ASR))
            w_n = W_A;
        w_sat = (w_n >= W_A);
        if (not_shift) begin
            w_dec_op = OP_PASS;
        end else if (imm && w_zero && w_type == ROR) begin
            w_dec_op = OP_RRX;
            w_dec_d  = {carry_in, x[WIDTH-1:1]};
            w_dec_c  = x[0];
        end else if (w_n != '0) begin
            unique case (w_type)
                LSL: begin
                    if (w_sat) begin
                        w_dec_d = '0;
                        w_dec_c = (w_n == W_A) ? x[0] : 1'b0;
                    end else begin
                        w_dec_op  = OP_LSL;
                        w_dec_amt = w_n[L-1:0];
                    end
                end
                LSR: begin
                    if (w_sat) begin
                        w_dec_d = '0;
                        w_dec_c = (w_n == W_A) ? x[WIDTH-1] : 1'b0;
                    end else begin
                        w_dec_op  = OP_LSR;
                        w_dec_amt = w_n[L-1:0];
                    end
                end
                ASR: begin
                    if (w_sat) begin
                        w_dec_d = {WIDTH{x[WIDTH-1]}};
                        w_dec_c = x[WIDTH-1];
                    end else begin
                        w_dec_op  = OP_ASR;
                        w_dec_amt = w_n[L-1:0];
                    end
                end
                ROR: begin
                    // Multiples of WIDTH rotate back to x with c = msb.
                    if (w_n[L-1:0] == '0) begin
                        w_dec_c = x[WIDTH-1];
                    end else begin
                        w_dec_op  = OP_ROR;
                        w_dec_amt = w_n[L-1:0];
                    end
                end
            endcase
        end
    end

    assign w_d[0]   = w_dec_d;
    assign w_c[0]   = w_dec_c;
    assign w_op[0]  = w_dec_op;
    assign w_amt[0] = w_dec_amt;

    for (genvar u = 1; u < U; u++) begin : g_lvl
        localparam int  ST    = stage_of(U, STAGES, u);
        localparam bit  FIRST = (first_unit(U, STAGES, ST) == u);
        logic [WIDTH-1:0] w_di;
        logic             w_ci;
        eff_op_t          w_oi;
        logic [L-1:0]     w_ai;
        if (FIRST) begin : g_reg
            assign w_di = r_data[ST-1];
            assign w_ci = r_carry[ST-1];
            assign w_oi = r_op[ST-1];
            assign w_ai = r_amt[ST-1];
        end else begin : g_comb
            assign w_di = w_d[u-1];
            assign w_ci = w_c[u-1];
            assign w_oi = w_op[u-1];
            assign w_ai = w_amt[u-1];
        end
        shifter_level #(
            .WIDTH (WIDTH),
            .AMT_W (L),
            .BIT   (u - 1)
        ) u_level (
            .i_data  (w_di),
            .i_carry (w_ci),
            .i_op    (w_oi),
            .i_amt   (w_ai),
            .o_data  (w_d[u]),
            .o_carry (w_c[u]),
            .o_op    (w_op[u]),
            .o_amt   (w_amt[u])
        );
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_cap
        localparam int LU = last_unit(U, STAGES, s);
        assign w_cd[s]   = w_d[LU];
        assign w_cc[s]   = w_c[LU];
        assign w_cop[s]  = w_op[LU];
        assign w_camt[s] = w_amt[LU];
    end

    assign w_advance = out_ready || !out_valid;
    assign in_ready  = w_advance && reset_n;
    assign w_vchain  = {r_valid, in_valid};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_valid <= '0;
            for (int s = 0; s < STAGES; s++) begin
                r_data[s]  <= '0;
                r_carry[s] <= 1'b0;
                r_op[s]    <= OP_PASS;
                r_amt[s]   <= '0;
            end
        end else if (w_advance) begin
            for (int s = 0; s < STAGES; s++) begin
                r_valid[s] <= w_vchain[s];
                r_data[s]  <= w_cd[s];
                r_carry[s] <= w_cc[s];
                r_op[s]    <= w_cop[s];
                r_amt[s]   <= w_camt[s];
            end
        end
    end

    assign out_valid = r_valid[STAGES-1];
    assign y         = r_data[STAGES-1];
    assign carry_out = r_carry[STAGES-1];

    assign w_unused = ^{r_amt[STAGES-1], r_op[STAGES-1], w_vchain[STAGES]};

endmodule

// File: tb/tb_pipelined_shifter.sv
// Directed + randomized bench for pipelined_shifter against a rule-level model.
// A slot-array model of the stalling pipe fixes exact output timing.
module tb_pipelined_shifter;

    localparam int W = 32;
    localparam int S = 2;

    typedef struct packed {
        logic [1:0]   t;
        logic [7:0]   n;
        logic         imm;
        logic         ns;
        logic         cin;
        logic [W-1:0] x;
    } req_t;

    typedef struct packed {
        logic         c;
        logic [W-1:0] y;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         in_valid, in_ready, imm, not_shift, carry_in;
    logic         out_valid, out_ready, carry_out;
    logic [1:0]   shift_type;
    logic [7:0]   shift_num;
    logic [W-1:0] x, y;

    logic         wv, wr1, wr7, wov1, wov7, wc1, wc7, wordy;
    logic [1:0]   wt;
    logic [7:0]   wn;
    logic [63:0]  wx, wy1, wy7;

    always #5 clk = ~clk;

    pipelined_shifter #(.WIDTH(32), .AMT_W(8), .STAGES(2)) u_dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .shift_type(shift_type), .shift_num(shift_num), .imm(imm),
        .not_shift(not_shift), .carry_in(carry_in), .x(x),
        .out_valid(out_valid), .out_ready(out_ready), .y(y), .carry_out(carry_out)
    );

    pipelined_shifter #(.WIDTH(64), .AMT_W(8), .STAGES(1)) u_dut64s1 (
        .clk(clk), .reset_n(reset_n), .in_valid(wv), .in_ready(wr1),
        .shift_type(wt), .shift_num(wn), .imm(1'b0),
        .not_shift(1'b0), .carry_in(1'b0), .x(wx),
        .out_valid(wov1), .out_ready(wordy), .y(wy1), .carry_out(wc1)
    );

    pipelined_shifter #(.WIDTH(64), .AMT_W(8), .STAGES(7)) u_dut64s7 (
        .clk(clk), .reset_n(reset_n), .in_valid(wv), .in_ready(wr7),
        .shift_type(wt), .shift_num(wn), .imm(1'b0),
        .not_shift(1'b0), .carry_in(1'b0), .x(wx),
        .out_valid(wov7), .out_ready(wordy), .y(wy7), .carry_out(wc7)
    );

    int   checks = 0;
    int   failures = 0;
    bit   mv [S];
    exp_t me [S];
    req_t rq [$];
    exp_t eq [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic exp_t mk(input logic [W-1:0] yy, input logic cc);
        exp_t e;
        e.y = yy;
        e.c = cc;
        return e;
    endfunction

    function automatic req_t mkr(input logic [1:0] t, input int n, input bit im,
                                 input bit ns, input bit ci, input logic [W-1:0] xx);
        req_t r;
        r.t = t; r.n = 8'(n); r.imm = im; r.ns = ns; r.cin = ci; r.x = xx;
        return r;
    endfunction

    function automatic exp_t model(input req_t r);
        int n, k;
        logic [W-1:0]   xx;
        logic [2*W-1:0] dbl;
        n  = int'(r.n);
        xx = r.x;
        if (r.ns) return mk(xx, r.cin);
        if (r.imm && n == 0) begin
            if (r.t == 2'd0) return mk(xx, r.cin);
            if (r.t == 2'd3) return mk({r.cin, xx[W-1:1]}, xx[0]);
            n = W;
        end else if (n == 0) begin
            return mk(xx, r.cin);
        end
        case (r.t)
            2'd0: begin
                if (n < W) return mk(xx << n, xx[W-n]);
                if (n == W) return mk('0, xx[0]);
                return mk('0, 1'b0);
            end
            2'd1: begin
                if (n < W) return mk(xx >> n, xx[n-1]);
                if (n == W) return mk('0, xx[W-1]);
                return mk('0, 1'b0);
            end
            2'd2: begin
                if (n < W) return mk(W'($signed(xx) >>> n), xx[n-1]);
                return mk({W{xx[W-1]}}, xx[W-1]);
            end
            default: begin
                k = n % W;
                if (k == 0) return mk(xx, xx[W-1]);
                dbl = {xx, xx} >> k;
                return mk(dbl[W-1:0], dbl[W-1]);
            end
        endcase
    endfunction

    function automatic bit busy();
        bit b;
        b = 1'b0;
        for (int i = 0; i < S; i++) b |= mv[i];
        return b;
    endfunction

    task automatic drive(input bit v, input req_t r, input bit ordy,
                         input exp_t e, output bit acc);
        bit adv;
        in_valid = v; shift_type = r.t; shift_num = r.n; imm = r.imm;
        not_shift = r.ns; carry_in = r.cin; x = r.x; out_ready = ordy;
        #1;
        adv = ordy || !mv[S-1];
        chk("out_valid", out_valid, mv[S-1]);
        if (mv[S-1]) begin
            chk("y", y, me[S-1].y);
            chk("carry_out", carry_out, me[S-1].c);
        end
        chk("in_ready", in_ready, adv);
        acc = v && adv;
        @(posedge clk);
        if (adv) begin
            for (int i = S - 1; i > 0; i--) begin
                mv[i] = mv[i-1];
                me[i] = me[i-1];
            end
            mv[0] = v;
            me[0] = e;
        end
        @(negedge clk);
    endtask

    // mode 0: always ready; 1: 3-cycle stall at cycles 3..5; 2: random.
    task automatic run_stream(input int mode, input int budget);
        int   idx, cyc;
        bit   v, ordy, acc;
        req_t r;
        exp_t e;
        idx = 0;
        cyc = 0;
        while ((idx < rq.size() || busy()) && cyc < budget) begin
            v = (idx < rq.size());
            if (mode == 2 && $urandom_range(0, 3) == 0) v = 1'b0;
            if (mode == 0) ordy = 1'b1;
            else if (mode == 1) ordy = !(cyc >= 3 && cyc < 6);
            else ordy = ($urandom_range(0, 3) != 0);
            r = '0;
            e = '0;
            if (v) begin
                r = rq[idx];
                e = eq[idx];
            end
            drive(v, r, ordy, e, acc);
            if (acc) idx++;
            cyc++;
        end
        chk("stream_budget", 64'(cyc < budget), 64'd1);
        rq.delete();
        eq.delete();
    endtask

    task automatic push(input req_t r, input exp_t e);
        rq.push_back(r);
        eq.push_back(e);
    endtask

    initial begin
        req_t r;
        bit   acc;
        int   l1, l7, n;
        reset_n = 1'b0; in_valid = 1'b0; shift_type = '0; shift_num = '0;
        imm = 1'b0; not_shift = 1'b0; carry_in = 1'b0; x = '0; out_ready = 1'b1;
        wv = 1'b0; wt = '0; wn = '0; wx = '0; wordy = 1'b1;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_y", y, 0);
        chk("rst_carry", carry_out, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_w1_valid", wov1, 0);
        chk("rst_w7_valid", wov7, 0);
        reset_n = 1'b1;

        // LSL boundaries, immediate #0 forms, ROR wrap, register #0, bypass.
        push(mkr(0, 1, 0, 0, 0, 32'hFFFFFFFF), mk(32'hFFFFFFFE, 1));
        push(mkr(0, 31, 0, 0, 0, 32'hFFFFFFFF), mk(32'h80000000, 1));
        push(mkr(0, 32, 0, 0, 0, 32'hFFFFFFFF), mk(32'h00000000, 1));
        push(mkr(0, 33, 0, 0, 0, 32'hFFFFFFFF), mk(32'h00000000, 0));
        push(mkr(1, 0, 1, 0, 0, 32'h80000000), mk(32'h00000000, 1));
        push(mkr(2, 0, 1, 0, 0, 32'h80000000), mk(32'hFFFFFFFF, 1));
        push(mkr(3, 0, 1, 0, 1, 32'h00000001), mk(32'h80000000, 1));
        push(mkr(3, 33, 0, 0, 0, 32'h00000001), mk(32'h80000000, 1));
        push(mkr(3, 32, 0, 0, 0, 32'h7FFFFFFF), mk(32'h7FFFFFFF, 0));
        push(mkr(1, 0, 0, 0, 1, 32'h12345678), mk(32'h12345678, 1));
        push(mkr(0, 5, 0, 1, 0, 32'hA5A5A5A5), mk(32'hA5A5A5A5, 0));
        run_stream(0, 60);

        // Back-pressure stream of 6.
        for (int i = 0; i < 6; i++) begin
            r = mkr(2'(i), 3 + 7 * i, 0, 0, i[0], 32'h80000001 + 32'(i * 32'h01010101));
            push(r, model(r));
        end
        run_stream(1, 60);

        // Reset with two requests in flight.
        r = mkr(0, 4, 0, 0, 0, 32'h0000000F);
        drive(1, r, 1, model(r), acc);
        r = mkr(1, 4, 0, 0, 0, 32'h000000F0);
        drive(1, r, 1, model(r), acc);
        reset_n = 1'b0;
        in_valid = 1'b1;
        #1;
        chk("mid_rst_in_ready", in_ready, 0);
        @(posedge clk);
        for (int i = 0; i < S; i++) mv[i] = 1'b0;
        @(negedge clk);
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_y", y, 0);
        chk("mid_rst_carry", carry_out, 0);
        reset_n = 1'b1;
        r = mkr(3, 8, 0, 0, 0, 32'hDEADBEEF);
        push(r, model(r));
        run_stream(0, 20);

        // W=64 with STAGES=1 and STAGES=7.
        wv = 1'b1; wt = 2'd2; wn = 8'd63; wx = 64'h8000000000000000;
        #1;
        chk("w1_in_ready", wr1, 1);
        chk("w7_in_ready", wr7, 1);
        @(posedge clk);
        @(negedge clk);
        wv = 1'b0;
        l1 = -1;
        l7 = -1;
        for (int k = 1; k <= 12; k++) begin
            #1;
            if (wov1 && l1 < 0) begin
                l1 = k;
                chk("w1_y", wy1, 64'hFFFFFFFFFFFFFFFF);
                chk("w1_c", wc1, 0);
            end
            if (wov7 && l7 < 0) begin
                l7 = k;
                chk("w7_y", wy7, 64'hFFFFFFFFFFFFFFFF);
                chk("w7_c", wc7, 0);
            end
            @(negedge clk);
        end
        chk("w1_latency", 64'(l1), 64'd1);
        chk("w7_latency", 64'(l7), 64'd7);

        // Randomized traffic with random stalls.
        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 5))
                0: n = 0;
                1: n = $urandom_range(1, 31);
                2: n = 32;
                3: n = $urandom_range(33, 255);
                4: n = $urandom_range(0, 40);
                default: n = $urandom_range(0, 255);
            endcase
            r = mkr(2'($urandom_range(0, 3)), n, ($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 7) == 0), 1'($urandom), $urandom);
            push(r, model(r));
        end
        run_stream(2, 3000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipelined_shifter.md
# pipelined_shifter

Parametrised, pipelined ARM-style barrel shifter for the datapath's operand-2 path. It adds carry-out generation and full ARM shift-amount semantics: register amounts ≥ WIDTH, and the immediate-encoding #0 special cases including RRX. A valid/ready handshake lets the execute stage stall it. It supersedes the combinational `Shifter`; the `not_shift` bypass behaves identically.

## Interface
- `WIDTH`, 32: data width; power of two, ≥ 8.
- `AMT_W`, 8: shift-amount width; must satisfy 2^AMT_W > WIDTH.
- `STAGES`, 2: pipeline register count; 1 ≤ STAGES ≤ log2(WIDTH)+1.
- `clk` in 1: single clock.
- `reset_n` in 1: synchronous, active-low reset.
- `in_valid` in 1: request present.
- `in_ready` out 1: request accepted on the rising edge when `in_valid && in_ready`.
- `shift_type` in 2: LSL=00, LSR=01, ASR=10, ROR=11.
- `shift_num` in AMT_W: shift amount.
- `imm` in 1: 1 selects immediate-encoding semantics for amount 0.
- `not_shift` in 1: bypass.
- `carry_in` in 1: current C flag.
- `x` in WIDTH: operand.
- `out_valid` out 1: result present.
- `out_ready` in 1: consumer accepts the result.
- `y` out WIDTH: result.
- `carry_out` out 1: shifter carry.

## Operation
Let n = `shift_num` and W = WIDTH. Rules are evaluated in this order; the first match wins.
- `not_shift`=1 → y=x, c=carry_in.
- `imm`=1, n=0:
  - LSL → y=x, c=carry_in.
  - LSR → treated as n=W.
  - ASR → treated as n=W.
  - ROR → RRX: y={carry_in, x[W-1:1]}, c=x[0].
- `imm`=0, n=0, any type → y=x, c=carry_in.
- LSL:
  - 0<n<W → y=x<<n, c=x[W-n].
  - n=W → y=0, c=x[0].
  - n>W → y=0, c=0.
- LSR:
  - 0<n<W → y=x>>n, c=x[n-1].
  - n=W → y=0, c=x[W-1].
  - n>W → y=0, c=0.
- ASR:
  - 0<n<W → arithmetic shift, c=x[n-1].
  - n≥W → y={W{x[W-1]}}, c=x[W-1].
- ROR, n≠0:
  - k = n mod W.
  - k=0 → y=x, c=x[W-1].
  - k≠0 → y=rotr(x,k), c=y[W-1].

Implementation structure:
- Decode (stage 0) reduces each request to:
  - effective type (LSL/LSR/ASR/ROR/RRX/PASS);
  - a saturation flag (n ≥ W);
  - a log2(W)-bit effective amount.
- Then log2(W) mux levels (1, 2, 4, … bit positions) are applied.
- The levels are split as evenly as possible across STAGES register boundaries; earlier stages take the extra levels.
- Carry is computed alongside the data and travels with it.

## Timing
- Latency: exactly STAGES cycles from the accept edge to `out_valid`=1, with no stalls.
- Throughput: one result per cycle.
- Global stall:
  - advance = `out_ready` || !`out_valid`.
  - `in_ready` = advance, driven combinationally.
  - All stage registers load only when advance=1.
  - A bubble enters when advance && !`in_valid`.
- While `out_valid` && !`out_ready`:
  - `y`, `carry_out` and `out_valid` hold stable;
  - no input is accepted.
- Simultaneous output pop and input accept in the same cycle: both happen; occupancy is unchanged.
- Reset (`reset_n`=0 at an edge):
  - all stage valid bits clear;
  - `out_valid`=0, `y`=0, `carry_out`=0;
  - in-flight requests are discarded;
  - `in_ready` is forced to 0 while `reset_n`=0.
- Mid-stream reset: the first valid output after reset belongs to the first request accepted after reset.
- Data registers in empty stages hold their contents; they are not required to be cleared.

## Structure
- `shifter_pkg` contains:
  - `shift_type_t` enum (LSL, LSR, ASR, ROR);
  - the internal `eff_op_t` (LSL, LSR, ASR, ROR, RRX, PASS);
  - function `clog2`-based level/stage partition constants.
- Sub-module `shifter_level`: one combinational mux level, parametrised by shift distance; it passes data, carry, `eff_op` and the remaining amount.
- The top level instantiates log2(W) levels via `generate` and inserts registers per the partition.

## Test plan
All scenarios use W=32, STAGES=2 unless stated.
1. **LSL boundaries:** LSL, `imm`=0, x=FFFFFFFF with n = 1 / 31 / 32 / 33 → y = FFFFFFFE / 80000000 / 0 / 0; c = 1 / 1 / 1 / 0. `out_valid` rises 2 cycles after accept.
2. **Immediate #0 forms:**
   - LSR with x=80000000 → y=0, c=1.
   - ASR with x=80000000 → y=FFFFFFFF, c=1.
   - ROR with `carry_in`=1, x=00000001 → y=80000000, c=1.
3. **ROR wrap and register #0:**
   - ROR n=33, x=00000001 → y=80000000, c=1.
   - ROR n=32, x=7FFFFFFF → y=7FFFFFFF, c=0.
   - `imm`=0, n=0, `carry_in`=1 → y=x, c=1.
4. **Back-pressure:** stream 6 back-to-back requests; hold `out_ready`=0 for 3 cycles mid-stream. Results must be in order and none lost or duplicated; `in_ready`=0 exactly while stalled with the pipe full; outputs are stable during the stall.
5. **Reset mid-operation:** assert `reset_n`=0 for 1 cycle with 2 requests in flight → `out_valid`=0 and `y`=0 next cycle; the next accepted request is the first result out.
6. **Parameter sweep:**
   - W=64, STAGES=1: ASR n=63, x=8000…0 → all ones, c=0; latency 1.
   - W=64, STAGES=7 → latency 7.
